// File: rtl/audio_envelope_pwm_pkg.sv
// Shared audio-path types and constants.
// Used by the envelope/PWM stage and later audio stages.
package audio_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ATTACK,
      SUSTAIN,
      RELEASE
   } env_state_t;

   localparam int PWM_W = 8;
   localparam logic [PWM_W-1:0] PWM_MID = 8'd128;

endpackage

// File: rtl/audio_envelope_pwm_if.sv
// Bundle between the song player and the envelope/PWM stage.
// master: player side (drives gate, tone, volume); slave: the stage.
interface audio_envelope_pwm_if;
   import audio_pkg::*;

   logic             playSound;
   logic             toneIn;
   logic [PWM_W-1:0] volume;
   logic             audPwm;
   logic             aud_sd;
   logic [7:0]       envLevel;
   logic             envIdle;

   modport master (
      output playSound, toneIn, volume,
      input  audPwm, aud_sd, envLevel, envIdle
   );

   modport slave (
      input  playSound, toneIn, volume,
      output audPwm, aud_sd, envLevel, envIdle
   );

endinterface

// File: rtl/audio_envelope_pwm_pwm_modulator.sv
// 8-bit PWM carrier: free-running counter, frame-latched duty.
// Ports: clock, reset, dutyNext (duty for next frame), force_low, audPwm.
module pwm_modulator
   import audio_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [PWM_W-1:0] dutyNext,
   input  logic             force_low,
   output logic             audPwm
);

   logic [PWM_W-1:0] pwmCnt;
   logic [PWM_W-1:0] dutyReg;

   // Duty is latched on the last count so every frame uses one value.
   always_ff @(posedge clock) begin
      if (reset) begin
         pwmCnt  <= '0;
         dutyReg <= PWM_MID;
         audPwm  <= 1'b0;
      end else begin
         pwmCnt <= pwmCnt + 1'b1;
         if (pwmCnt == '1)
            dutyReg <= dutyNext;
         audPwm <= !force_low && (pwmCnt < dutyReg);
      end
   end

endmodule

// File: rtl/audio_envelope_pwm.sv
// Envelope (attack/sustain/release) + volume scaling ahead of PWM.
// Ports: clock, reset, bus (slave: playSound, toneIn, volume in;
//        audPwm, aud_sd, envLevel, envIdle out).
module audio_envelope_pwm
   import audio_pkg::*;
#(
   parameter int ATTACK_STEP_CYCLES  = 50_000,
   parameter int RELEASE_STEP_CYCLES = 200_000,
   parameter int STEP_CNT_W          = 18
) (
   input logic                 clock,
   input logic                 reset,
   audio_envelope_pwm_if.slave bus
);

   localparam logic [STEP_CNT_W-1:0] ATK_LAST =
      STEP_CNT_W'(ATTACK_STEP_CYCLES - 1);
   localparam logic [STEP_CNT_W-1:0] REL_LAST =
      STEP_CNT_W'(RELEASE_STEP_CYCLES - 1);

   env_state_t            state;
   logic [STEP_CNT_W-1:0] stepCnt;
   logic [7:0]            envLevel;
   logic                  aud_sd;
   logic                  envIdle;

   logic                  atk_tick;
   logic                  rel_tick;
   logic [15:0]           prod;
   logic [7:0]            amp;
   logic [6:0]            half;
   logic [PWM_W-1:0]      dutyNext;

   assign atk_tick = (stepCnt == ATK_LAST);
   assign rel_tick = (stepCnt == REL_LAST);

   // envIdle/aud_sd are set alongside the state change so they
   // track the state register exactly.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         stepCnt  <= '0;
         envLevel <= 8'd0;
         aud_sd   <= 1'b0;
         envIdle  <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               stepCnt <= '0;
               if (bus.playSound) begin
                  state   <= ATTACK;
                  envIdle <= 1'b0;
                  aud_sd  <= 1'b1;
               end
            end
            ATTACK: begin
               if (!bus.playSound) begin
                  state   <= RELEASE;
                  stepCnt <= '0;
               end else if (envLevel == 8'hFF) begin
                  // resumed from RELEASE before its first tick
                  state   <= SUSTAIN;
                  stepCnt <= '0;
               end else if (atk_tick) begin
                  stepCnt  <= '0;
                  envLevel <= envLevel + 8'd1;
                  if (envLevel == 8'hFE)
                     state <= SUSTAIN;
               end else begin
                  stepCnt <= stepCnt + 1'b1;
               end
            end
            SUSTAIN: begin
               stepCnt <= '0;
               if (!bus.playSound)
                  state <= RELEASE;
            end
            RELEASE: begin
               if (bus.playSound) begin
                  state   <= ATTACK;
                  stepCnt <= '0;
               end else if (envLevel == 8'd0) begin
                  state   <= IDLE;
                  stepCnt <= '0;
                  envIdle <= 1'b1;
                  aud_sd  <= 1'b0;
               end else if (rel_tick) begin
                  stepCnt  <= '0;
                  envLevel <= envLevel - 8'd1;
                  if (envLevel == 8'd1) begin
                     state   <= IDLE;
                     envIdle <= 1'b1;
                     aud_sd  <= 1'b0;
                  end
               end else begin
                  stepCnt <= stepCnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Swing around the midpoint; amp 0 leaves a silent 50% duty.
   assign prod     = 16'(envLevel) * 16'(bus.volume);
   assign amp      = prod[15:8];
   assign half     = amp[7:1];
   assign dutyNext = bus.toneIn ? PWM_MID + {1'b0, half}
                                : PWM_MID - {1'b0, half};

   pwm_modulator u_pwm (
      .clock     (clock),
      .reset     (reset),
      .dutyNext  (dutyNext),
      .force_low (state == IDLE),
      .audPwm    (bus.audPwm)
   );

   assign bus.envLevel = envLevel;
   assign bus.envIdle  = envIdle;
   assign bus.aud_sd   = aud_sd;

endmodule
